// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch slice: FSM states, buffered entry
// layout and the NOP word driven toward decode when nothing is valid.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DROP
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Request/response bus between the fetch controller and instruction memory.
// At most one request is outstanding; responses arrive in order without backpressure.
interface fetch_ctrl_if;

    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush beats push/pop.
// The head entry is read straight from the storage registers.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  push_data,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_en, pop_en;

    // Pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        push_en  = push && !flush;
        pop_en   = pop && !flush && (count_q != '0);
        wr_ptr_d = push_en ? bump(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_en ? bump(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else if (push_en && !pop_en) begin
            count_d = count_q + 1'b1;
        end else if (pop_en && !push_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, keeps at most one imem request in flight,
// buffers responses for decode and discards wrong-path words after a redirect.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         redirect_d,
    input  logic [31:0]  redirect_pc_d,
    input  logic         stall_d,
    fetch_ctrl_if.master imem,
    output logic         valid_f,
    output logic [31:0]  instr_f,
    output logic [31:0]  pc_f,
    output logic [31:0]  pc_plus_4_f
);

    localparam int          CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          rsp_done, pending, drain, req, accept, push, pop;
    logic [CW:0]   occ, lim;
    logic [CW-1:0] count;
    fetch_entry_t  head, rsp_entry;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_d),
        .push_data (rsp_entry),
        .count     (count),
        .head      (head)
    );

    assign valid_f     = (count != '0);
    assign instr_f     = valid_f ? head.instr : NOP;
    assign pc_f        = valid_f ? head.pc : NOP;
    assign pc_plus_4_f = pc_f + 32'd4;
    assign drain       = valid_f && !stall_d;
    assign pop         = drain && !redirect_d;

    always_comb begin
        rsp_done  = imem.rvalid && (state_q != IDLE);
        // A word landing this cycle in BUSY still occupies a slot; a same-cycle
        // pop frees one. Counting both keeps occupancy within FIFO_DEPTH.
        pending   = (state_q == BUSY) || ((state_q == DROP) && !rsp_done);
        occ       = {1'b0, count} + {{CW{1'b0}}, pending};
        lim       = DEPTH_LIM + {{CW{1'b0}}, drain};
        req       = !reset && !redirect_d && ((state_q == IDLE) || rsp_done) && (occ < lim);
        accept    = req && imem.ready;
        push      = rsp_done && (state_q == BUSY) && !redirect_d;
        rsp_entry = '{pc: req_pc_q, instr: imem.rdata};

        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (redirect_d) begin
            pc_d    = redirect_pc_d;
            state_d = ((state_q != IDLE) && !rsp_done) ? DROP : IDLE;
        end else if (accept) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
            state_d  = BUSY;
        end else if (rsp_done) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign imem.req  = req;
    assign imem.addr = pc_q;

endmodule
